// File: rtl/rcu_pkt_pkg.sv
// Shared types for the packet receive control unit: FSM states and error codes.
package rcu_pkt_pkg;

    localparam int unsigned EOP_CNT_W = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_READ,
        ST_WRITE,
        ST_EOP_CHK,
        ST_DONE_WAIT,
        ST_ERR,
        ST_ERR_EOP,
        ST_EIDLE
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_BAD_SYNC  = 3'd1,
        ERR_EARLY_EOP = 3'd2,
        ERR_BAD_EOP   = 3'd3,
        ERR_OVERFLOW  = 3'd4
    } err_code_e;

endpackage

// File: rtl/rcu_pkt_flex_counter.sv
// Saturating up-counter with synchronous clear; holds once it reaches sat_val_i.
module rcu_pkt_flex_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear_i,
    input  logic         count_en_i,
    input  logic [W-1:0] sat_val_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_en_i && (count_q != sat_val_i)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/rcu_pkt.sv
// Packet receive control unit: checks sync, hands data bytes to the FIFO,
// validates the EOP and reports the first error cause of a packet.
module rcu_pkt
    import rcu_pkt_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = 8'h80,
    parameter int unsigned MAX_BYTES = 64,
    parameter int unsigned EOP_BITS  = 2,
    localparam int unsigned CNT_W    = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             d_edge,
    input  logic             eop,
    input  logic             shift_enable,
    input  logic [7:0]       rcv_data,
    input  logic             byte_received,
    output logic             rcving,
    output logic             w_enable,
    output logic             r_error,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] byte_count,
    output logic             pkt_done
);

    state_e                 state_q, state_d;
    err_code_e              err_q, err_d;
    logic [EOP_CNT_W-1:0]   eop_cnt_q, eop_cnt_d;
    logic                   rcving_q, rcving_d;
    logic                   w_enable_q, w_enable_d;
    logic                   r_error_q, r_error_d;
    logic                   pkt_done_q, pkt_done_d;
    logic                   sync_entry_c;

    // Next-state, error capture and the next-cycle view of the Moore outputs.
    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        eop_cnt_d = eop_cnt_q;

        unique case (state_q)
            ST_IDLE: if (d_edge) state_d = ST_SYNC;
            ST_SYNC: begin
                if (eop) begin
                    state_d = ST_ERR_EOP;
                    err_d   = ERR_EARLY_EOP;
                end else if (byte_received) begin
                    if (rcv_data == SYNC_BYTE) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = ERR_BAD_SYNC;
                    end
                end
            end
            ST_READ: begin
                if (eop) begin
                    state_d = ST_ERR_EOP;
                    err_d   = ERR_EARLY_EOP;
                end else if (byte_received) begin
                    if (byte_count == CNT_W'(MAX_BYTES)) begin
                        state_d = ST_ERR;
                        err_d   = ERR_OVERFLOW;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (eop) begin
                    state_d = ST_ERR_EOP;
                    err_d   = ERR_EARLY_EOP;
                end else begin
                    state_d = ST_EOP_CHK;
                end
            end
            ST_EOP_CHK: begin
                if (shift_enable) begin
                    if (eop) begin
                        eop_cnt_d = eop_cnt_q + EOP_CNT_W'(1);
                        if (eop_cnt_d == EOP_CNT_W'(EOP_BITS)) state_d = ST_DONE_WAIT;
                    end else if (eop_cnt_q == '0) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = ERR_BAD_EOP;
                    end
                end
            end
            ST_DONE_WAIT: if (d_edge) state_d = ST_IDLE;
            ST_ERR:       if (eop) state_d = ST_ERR_EOP;
            ST_ERR_EOP:   if (!eop && d_edge) state_d = ST_EIDLE;
            ST_EIDLE:     if (d_edge) state_d = ST_SYNC;
            default:      state_d = ST_IDLE;
        endcase

        // A fresh EOP check always starts counting SE0 bits from zero.
        if ((state_d == ST_EOP_CHK) && (state_q != ST_EOP_CHK)) eop_cnt_d = '0;

        sync_entry_c = (state_d == ST_SYNC) && (state_q != ST_SYNC);
        if (sync_entry_c) err_d = ERR_NONE;

        rcving_d   = state_d inside {ST_SYNC, ST_READ, ST_WRITE, ST_EOP_CHK,
                                     ST_DONE_WAIT, ST_ERR, ST_ERR_EOP};
        r_error_d  = state_d inside {ST_ERR, ST_ERR_EOP, ST_EIDLE};
        w_enable_d = (state_d == ST_WRITE);
        pkt_done_d = (state_d == ST_DONE_WAIT) && (state_q != ST_DONE_WAIT);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            err_q      <= ERR_NONE;
            eop_cnt_q  <= '0;
            rcving_q   <= 1'b0;
            w_enable_q <= 1'b0;
            r_error_q  <= 1'b0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            eop_cnt_q  <= eop_cnt_d;
            rcving_q   <= rcving_d;
            w_enable_q <= w_enable_d;
            r_error_q  <= r_error_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    // Data byte count: cleared on sync entry, bumped as each WRITE cycle completes.
    rcu_pkt_flex_counter #(
        .W(CNT_W)
    ) u_flex_counter (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear_i    (sync_entry_c),
        .count_en_i (state_q == ST_WRITE),
        .sat_val_i  (CNT_W'(MAX_BYTES)),
        .count_o    (byte_count)
    );

    assign rcving   = rcving_q;
    assign w_enable = w_enable_q;
    assign r_error  = r_error_q;
    assign pkt_done = pkt_done_q;
    assign err_code = err_q;

endmodule

// File: tb/tb_rcu_pkt.sv
// Packet-level bench for rcu_pkt: drives whole packets of random kinds and
// compares end-of-packet results against an outcome table per packet kind.
module tb_rcu_pkt;

    localparam int unsigned MAXB = 4;
    localparam int unsigned EOPB = 2;
    localparam int unsigned CW   = $clog2(MAXB + 1);

    localparam int K_GOOD    = 0;
    localparam int K_BADSYNC = 1;
    localparam int K_EARLY   = 2;
    localparam int K_BADEOP  = 3;
    localparam int K_OVF     = 4;
    localparam int K_RESET   = 5;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          d_edge = 1'b0;
    logic          eop = 1'b0;
    logic          shift_enable = 1'b0;
    logic [7:0]    rcv_data = 8'h00;
    logic          byte_received = 1'b0;
    logic          rcving, w_enable, r_error, pkt_done;
    logic [2:0]    err_code;
    logic [CW-1:0] byte_count;

    int n_vec = 0;
    int n_mis = 0;
    int wen_tot = 0;
    int done_tot = 0;

    rcu_pkt #(
        .SYNC_BYTE (8'h80),
        .MAX_BYTES (MAXB),
        .EOP_BITS  (EOPB)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .d_edge        (d_edge),
        .eop           (eop),
        .shift_enable  (shift_enable),
        .rcv_data      (rcv_data),
        .byte_received (byte_received),
        .rcving        (rcving),
        .w_enable      (w_enable),
        .r_error       (r_error),
        .err_code      (err_code),
        .byte_count    (byte_count),
        .pkt_done      (pkt_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (w_enable === 1'b1) wen_tot++;
        if (pkt_done === 1'b1) done_tot++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic de, input logic ep, input logic se,
                        input logic br, input logic [7:0] d);
        @(negedge clk);
        d_edge        = de;
        eop           = ep;
        shift_enable  = se;
        byte_received = br;
        rcv_data      = d;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // One data byte; a non-final byte is followed by a J bit sample.
    task automatic send_byte(input logic last);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom));
        idle();
        if (!last) begin
            repeat ($urandom_range(0, 2)) idle();
            step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rcving"},   32'(rcving),     32'd0);
        chk({tag, "_w_enable"}, 32'(w_enable),   32'd0);
        chk({tag, "_r_error"},  32'(r_error),    32'd0);
        chk({tag, "_pkt_done"}, 32'(pkt_done),   32'd0);
        chk({tag, "_err_code"}, 32'(err_code),   32'd0);
        chk({tag, "_bcount"},   32'(byte_count), 32'd0);
    endtask

    task automatic run_pkt(input int kind, input int k, input logic [7:0] bad_sync);
        int base_w, base_d;
        int exp_w, exp_d, exp_e, exp_bc, exp_re;
        logic reset_hit;
        base_w    = wen_tot;
        base_d    = done_tot;
        reset_hit = 1'b0;

        // Outcome table: each packet kind yields writes, done pulses, code, count, error flag.
        exp_d  = 0;
        exp_re = 1;
        case (kind)
            K_GOOD:    begin exp_w = k;         exp_d = 1; exp_e = 0; exp_bc = k;         exp_re = 0; end
            K_BADSYNC: begin exp_w = 0;                    exp_e = 1; exp_bc = 0;                     end
            K_EARLY:   begin exp_w = k;                    exp_e = 2; exp_bc = k;                     end
            K_BADEOP:  begin exp_w = k;                    exp_e = 3; exp_bc = k;                     end
            K_OVF:     begin exp_w = int'(MAXB);           exp_e = 4; exp_bc = int'(MAXB);            end
            default:   begin exp_w = k;                    exp_e = 0; exp_bc = 0;         exp_re = 0; end
        endcase

        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        idle();
        chk("sync_rcving", 32'(rcving),     32'd1);
        chk("sync_errclr", 32'(err_code),   32'd0);
        chk("sync_bcclr",  32'(byte_count), 32'd0);

        if (kind == K_BADSYNC) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, bad_sync);
        end else begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 8'h80);
            case (kind)
                K_GOOD: begin
                    for (int i = 0; i < k; i++) send_byte(i == k - 1);
                    repeat (EOPB) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
                    idle();
                    chk("done_rcving", 32'(rcving), 32'd1);
                    idle();
                    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
                end
                K_EARLY: begin
                    for (int i = 0; i < k; i++) send_byte(1'b0);
                    step(1'b0, 1'b1, 1'b0, 1'b1, 8'($urandom));
                end
                K_BADEOP: begin
                    for (int i = 0; i < k; i++) send_byte(i == k - 1);
                    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
                    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
                end
                K_OVF: begin
                    for (int i = 0; i < int'(MAXB); i++) send_byte(1'b0);
                    step(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom));
                end
                default: begin
                    for (int i = 0; i < k; i++) send_byte(1'b0);
                    idle();
                    @(negedge clk);
                    #2 n_rst = 1'b0;
                    #1 chk_all_zero("rst_mid");
                    reset_hit = 1'b1;
                    @(negedge clk);
                    n_rst = 1'b1;
                end
            endcase
        end

        if (!reset_hit) begin
            idle();
            if (exp_re == 1) begin
                chk("err_entry_rerr", 32'(r_error),  32'd1);
                chk("err_entry_code", 32'(err_code), 32'(exp_e));
                // Close out the failed packet: SE0 then an idle edge.
                step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
                step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
                step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
                chk("erreop_hold", 32'(rcving), 32'd1);
                step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
                idle();
            end
        end

        chk("pkt_wen_pulses",  32'(wen_tot - base_w),  32'(exp_w));
        chk("pkt_done_pulses", 32'(done_tot - base_d), 32'(exp_d));
        chk("pkt_err_code",    32'(err_code),          32'(exp_e));
        chk("pkt_byte_count",  32'(byte_count),        32'(exp_bc));
        chk("pkt_r_error",     32'(r_error),           32'(exp_re));
        chk("pkt_rcving",      32'(rcving),            32'd0);
        chk("pkt_w_enable",    32'(w_enable),          32'd0);
    endtask

    initial begin
        int kind, k;
        logic [7:0] bs;
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        n_rst = 1'b1;
        repeat (2) idle();

        run_pkt(K_GOOD,    3, 8'h00);
        run_pkt(K_BADSYNC, 0, 8'h81);
        run_pkt(K_OVF,     0, 8'h00);
        run_pkt(K_BADEOP,  2, 8'h00);
        run_pkt(K_EARLY,   2, 8'h00);
        run_pkt(K_RESET,   2, 8'h00);
        run_pkt(K_GOOD,    int'(MAXB), 8'h00);
        run_pkt(K_EARLY,   0, 8'h00);

        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 5));
            case (kind)
                K_GOOD, K_BADEOP: k = int'($urandom_range(1, MAXB));
                K_EARLY:          k = int'($urandom_range(0, MAXB - 1));
                K_RESET:          k = int'($urandom_range(0, MAXB));
                default:          k = 0;
            endcase
            do bs = 8'($urandom); while (bs == 8'h80);
            repeat ($urandom_range(0, 3)) idle();
            run_pkt(kind, k, bs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/rcu_pkt.md
RCU_PKT -- requirements
Module: rcu_pkt

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'h80, expected sync pattern.
REQ-002 SHALL have parameter MAX_BYTES, default 64, maximum data bytes per packet (1..255).
REQ-003 SHALL have parameter EOP_BITS, default 2, consecutive SE0 bit periods constituting a valid EOP (1..4).
REQ-004 SHALL have derived localparam CNT_W = $clog2(MAX_BYTES+1).
REQ-005 SHALL have port clk  in  1  clock; reset n_rst, asynchronous, active-low; clock clk.
REQ-006 SHALL have port n_rst  in  1  async active-low reset.
REQ-007 SHALL have port d_edge  in  1  line transition detected this cycle.
REQ-008 SHALL have port eop  in  1  SE0 present this cycle.
REQ-009 SHALL have port shift_enable  in  1  bit-period sample strobe.
REQ-010 SHALL have port rcv_data  in  8  last assembled byte.
REQ-011 SHALL have port byte_received  in  1  one-cycle pulse, rcv_data valid.
REQ-012 SHALL have port rcving  out  1  packet reception in progress.
REQ-013 SHALL have port w_enable  out  1  one-cycle FIFO write strobe.
REQ-014 SHALL have port r_error  out  1  packet error flag.
REQ-015 SHALL have port err_code  out  3  0 none, 1 BAD_SYNC, 2 EARLY_EOP, 3 BAD_EOP, 4 OVERFLOW.
REQ-016 SHALL have port byte_count  out  CNT_W  data bytes written in current/last packet.
REQ-017 SHALL have port pkt_done  out  1  one-cycle pulse on valid packet end.

Function
REQ-018 SHALL implement Moore FSM: IDLE, SYNC, READ, WRITE, EOP_CHK, DONE_WAIT, ERR, ERR_EOP, EIDLE.
REQ-019 IDLE: d_edge -> SYNC; else hold.
REQ-020 SYNC: eop -> ERR_EOP (EARLY_EOP); byte_received & rcv_data==SYNC_BYTE -> READ; byte_received & mismatch -> ERR (BAD_SYNC); else hold.
REQ-021 READ: eop -> ERR_EOP (EARLY_EOP), priority over byte_received; byte_received & byte_count==MAX_BYTES -> ERR (OVERFLOW); byte_received otherwise -> WRITE.
REQ-022 WRITE: exactly one cycle, w_enable=1, byte_count increments; next eop -> ERR_EOP (EARLY_EOP), else EOP_CHK.
REQ-023 EOP_CHK: on shift_enable & eop, eop_cnt increments; when it reaches EOP_BITS -> DONE_WAIT; on shift_enable & !eop with eop_cnt==0 -> READ, with eop_cnt>0 -> ERR (BAD_EOP); no shift_enable -> hold.
REQ-024 eop_cnt SHALL clear on every entry to EOP_CHK.
REQ-025 DONE_WAIT: pkt_done=1 on the first cycle only; d_edge -> IDLE.
REQ-026 ERR: eop -> ERR_EOP; else hold.
REQ-027 ERR_EOP: hold while eop=1 or d_edge=0; !eop & d_edge -> EIDLE.
REQ-028 EIDLE: d_edge -> SYNC; else hold.
REQ-029 Outputs: rcving=1 in SYNC, READ, WRITE, EOP_CHK, DONE_WAIT, ERR, ERR_EOP; r_error=1 in ERR, ERR_EOP, EIDLE; w_enable=1 only in WRITE.
REQ-030 err_code SHALL be registered, loaded on error entry, held until next SYNC entry, where it clears to 0 together with byte_count.
REQ-031 First error cause SHALL win; ERR -> ERR_EOP does not overwrite err_code.
REQ-032 byte_count SHALL saturate at MAX_BYTES, never wrap, and hold after DONE_WAIT/errors.

Reset
REQ-033 n_rst low SHALL force IDLE, eop_cnt=0, byte_count=0, err_code=0, all 1-bit outputs 0, including mid-packet.

Structure
REQ-034 State enum and err_code enum SHALL live in shared package rcu_pkt_pkg.
REQ-035 byte_count SHALL use one flex_counter instance (clear on SYNC entry, count on WRITE); eop_cnt inline.

Verification
REQ-036 Sync 8'h80, 3 bytes, 2-bit EOP, d_edge -> 3 w_enable pulses, byte_count=3, pkt_done once, err_code=0, IDLE.
REQ-037 Sync byte 8'h81 -> ERR, r_error=1, err_code=1; after EOP then d_edge -> EIDLE; next d_edge -> SYNC, err_code=0.
REQ-038 MAX_BYTES=4, 5 data bytes -> 4 w_enable pulses, 5th byte -> ERR, err_code=4, byte_count=4.
REQ-039 EOP_BITS=2, one SE0 bit then J -> ERR, err_code=3; eop asserted in READ with byte_received same cycle -> ERR_EOP, err_code=2, no w_enable.
REQ-040 n_rst asserted during READ after 2 bytes -> IDLE immediately, byte_count=0, all outputs 0.
